// File: rtl/systolic_scheduler.sv
// Control sequencer for an N x N weight-stationary systolic array.
// Each tile runs a weight-load phase (broadcast or row-sequential), then a
// multiply phase where row r is enabled PE_LATENCY cycles after row r-1.
// A job runs a programmable number of tiles back to back. Every output is a
// flop, so the stall input only acts on the cycle after it is sampled.
module systolic_scheduler #(
    parameter int MATRIX_SIZE = 2,
    parameter int PE_LATENCY  = 4,
    parameter int TILE_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   general_enable,
    input  logic                   start,
    input  logic                   load_mode,
    input  logic [TILE_W-1:0]      tile_count,
    output logic                   busy,
    output logic [MATRIX_SIZE-1:0] load_weight,
    output logic [MATRIX_SIZE-1:0] enable_mult,
    output logic                   tile_done,
    output logic                   done
);

    localparam int N        = MATRIX_SIZE;
    localparam int L        = PE_LATENCY;
    localparam int MULT_LEN = (2 * N - 1) * L;
    // MULT_LEN >= 3, so at least two bits; it also covers the N-cycle load phase
    localparam int CNT_W    = $clog2(MULT_LEN);

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MULT = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  idx;         // cycle index inside the current phase
    logic [TILE_W-1:0] tiles_left;  // tiles remaining, including the current one
    logic              mode;        // captured load_mode for the whole job

    // Row strobes for load cycle k: all rows in broadcast, one-hot row k otherwise
    function automatic logic [N-1:0] load_mask(input logic seq, input logic [CNT_W-1:0] k);
        logic [N-1:0] mask;
        if (seq) begin
            mask = '0;
            for (int r = 0; r < N; r++) begin
                if (int'(k) == r) mask[r] = 1'b1;
            end
        end else begin
            mask = '1;
        end
        return mask;
    endfunction

    // Row r multiplies for N*L cycles starting at multiply index r*L
    function automatic logic [N-1:0] mult_mask(input logic [CNT_W-1:0] m);
        logic [N-1:0] mask;
        int           mi;
        mi = int'(m);
        for (int r = 0; r < N; r++) begin
            mask[r] = (mi >= r * L) && (mi < (r + N) * L);
        end
        return mask;
    endfunction

    // Sequencer: state, counters and registered outputs advance only on enabled edges
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            tiles_left  <= '0;
            mode        <= 1'b0;
            busy        <= 1'b0;
            load_weight <= '0;
            enable_mult <= '0;
            tile_done   <= 1'b0;
            done        <= 1'b0;
        end else if (!general_enable) begin
            // Stalled cycle: strobes and pulses are masked, everything else holds.
            // Pulses are only produced on enabled edges, so none are lost here.
            load_weight <= '0;
            enable_mult <= '0;
            tile_done   <= 1'b0;
            done        <= 1'b0;
        end else begin
            load_weight <= '0;
            enable_mult <= '0;
            tile_done   <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= LOAD;
                        idx         <= '0;
                        mode        <= load_mode;
                        tiles_left  <= (tile_count == '0) ? TILE_W'(1) : tile_count;
                        busy        <= 1'b1;
                        load_weight <= load_mask(load_mode, CNT_W'(0));
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    if (idx == LOAD_LAST) begin
                        state       <= MULT;
                        idx         <= '0;
                        enable_mult <= mult_mask(CNT_W'(0));
                    end else begin
                        idx         <= idx + CNT_W'(1);
                        load_weight <= load_mask(mode, idx + CNT_W'(1));
                    end
                end
                MULT: begin
                    if (idx == MULT_LAST) begin
                        idx       <= '0;
                        tile_done <= 1'b1;
                        if (tiles_left > TILE_W'(1)) begin
                            tiles_left  <= tiles_left - TILE_W'(1);
                            state       <= LOAD;
                            load_weight <= load_mask(mode, CNT_W'(0));
                        end else begin
                            tiles_left <= '0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                        end
                    end else begin
                        idx         <= idx + CNT_W'(1);
                        enable_mult <= mult_mask(idx + CNT_W'(1));
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_scheduler.sv
// Bench for systolic_scheduler: two instances (N=2,L=4 and N=4,L=2) share
// the same inputs; each is compared every cycle with a frame-list model that
// expands a job into its per-cycle output frames, plus directed sequences.
module tb_systolic_scheduler;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, ge, start, mode;
    logic [7:0] tc;

    logic       busy2, td2, dn2;
    logic [1:0] lw2, em2;
    logic       busy4, td4, dn4;
    logic [3:0] lw4, em4;

    systolic_scheduler #(.MATRIX_SIZE(2), .PE_LATENCY(4), .TILE_W(8)) dut2 (
        .clk(clk), .reset(rst), .general_enable(ge), .start(start),
        .load_mode(mode), .tile_count(tc), .busy(busy2), .load_weight(lw2),
        .enable_mult(em2), .tile_done(td2), .done(dn2)
    );

    systolic_scheduler #(.MATRIX_SIZE(4), .PE_LATENCY(2), .TILE_W(8)) dut4 (
        .clk(clk), .reset(rst), .general_enable(ge), .start(start),
        .load_mode(mode), .tile_count(tc), .busy(busy4), .load_weight(lw4),
        .enable_mult(em4), .tile_done(td4), .done(dn4)
    );

    typedef struct packed {
        logic [3:0] lw;
        logic [3:0] em;
        logic       busy;
        logic       td;
        logic       dn;
    } frame_t;

    typedef struct packed {
        logic       start;
        logic [1:0] lw;
        logic [1:0] em;
        logic       busy;
        logic       td;
        logic       dn;
    } vec_t;

    frame_t fifo [2][256];
    int     head [2];
    int     tail [2];
    frame_t expv [2];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    vec_t   tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
        end
    endtask

    // Expand one job into the list of frames it presents on enabled cycles
    task automatic build_job(input int i, input logic m, input logic [7:0] t_in);
        int     n, l, t_eff;
        frame_t f;
        n = (i == 0) ? 2 : 4;
        l = (i == 0) ? 4 : 2;
        t_eff = (t_in == 0) ? 1 : int'(t_in);
        head[i] = 0;
        tail[i] = 0;
        for (int t = 0; t < t_eff; t++) begin
            for (int k = 0; k < n; k++) begin
                f = '0;
                f.busy = 1'b1;
                f.lw = m ? 4'(1 << k) : 4'((1 << n) - 1);
                f.td = (t > 0) && (k == 0);
                fifo[i][tail[i]] = f;
                tail[i]++;
            end
            for (int mi = 0; mi < (2 * n - 1) * l; mi++) begin
                f = '0;
                f.busy = 1'b1;
                for (int r = 0; r < n; r++) begin
                    if (mi >= r * l && mi < (r + n) * l) f.em[r] = 1'b1;
                end
                fifo[i][tail[i]] = f;
                tail[i]++;
            end
        end
        f = '0;
        f.td = 1'b1;
        f.dn = 1'b1;
        fifo[i][tail[i]] = f;
        tail[i]++;
    endtask

    task automatic model_edge(input int i);
        if (rst) begin
            head[i] = 0;
            tail[i] = 0;
            expv[i] = '0;
        end else if (!ge) begin
            expv[i].lw = '0;
            expv[i].em = '0;
            expv[i].td = 1'b0;
            expv[i].dn = 1'b0;
        end else begin
            if (head[i] == tail[i] && start) build_job(i, mode, tc);
            if (head[i] != tail[i]) begin
                expv[i] = fifo[i][head[i]];
                head[i]++;
            end else begin
                expv[i] = '0;
            end
        end
    endtask

    function automatic frame_t actual(input int i);
        frame_t f;
        if (i == 0) begin
            f.lw = {2'b00, lw2}; f.em = {2'b00, em2};
            f.busy = busy2; f.td = td2; f.dn = dn2;
        end else begin
            f.lw = lw4; f.em = em4;
            f.busy = busy4; f.td = td4; f.dn = dn4;
        end
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        cyc++;
        chk("model_n2", 32'(actual(0)), 32'(expv[0]));
        chk("model_n4", 32'(actual(1)), 32'(expv[1]));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((head[0] != tail[0] || head[1] != tail[1]) && k < 300) begin
            tick();
            k++;
        end
        chk("idle_timeout", 32'(k < 300), 32'(1));
        tick();
    endtask

    initial begin
        int n_dn2, n_dn4;

        // Expected trace of a single broadcast tile, N=2 L=4 (row i -> cycle i+1)
        tbl[0]  = '{1'b1, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

        head[0] = 0; tail[0] = 0; head[1] = 0; tail[1] = 0;
        expv[0] = '0; expv[1] = '0;
        rst = 1'b1; ge = 1'b1; start = 1'b0; mode = 1'b0; tc = 8'd1;
        tick();
        tick();
        chk("reset_n2", {busy2, lw2, em2, td2, dn2}, 32'(0));
        chk("reset_n4", {busy4, lw4, em4, td4, dn4}, 32'(0));
        rst = 1'b0;
        tick();

        // Single broadcast tile against the constant table
        mode = 1'b0; tc = 8'd1;
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start;
            tick();
            chk("table_n2", {lw2, em2, busy2, td2, dn2},
                {tbl[i].lw, tbl[i].em, tbl[i].busy, tbl[i].td, tbl[i].dn});
        end
        wait_idle();

        // Sequential load, N=4 L=2: one-hot rows, row 3 enabled MULT 6..13
        mode = 1'b1; tc = 8'd1; start = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            start = 1'b0;
            if (c >= 1 && c <= 4) chk("seq_lw_n4", lw4, 32'(1 << (c - 1)));
            if (c == 10) chk("row3_before", em4[3], 32'(0));
            if (c == 11) chk("row3_rise", em4[3], 32'(1));
            if (c == 18) chk("row3_last", em4[3], 32'(1));
            if (c == 19) chk("row3_fall_done", {em4[3], dn4}, 32'(1));
        end
        wait_idle();

        // Three tiles: tile_done at 15 and 29 inside LOAD, done only at 43
        mode = 1'b0; tc = 8'd3; start = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            tick();
            start = 1'b0;
            chk("multi_td", td2, 32'(c == 15 || c == 29 || c == 43));
            chk("multi_done", dn2, 32'(c == 43));
            if (c == 15 || c == 29) chk("multi_tile_busy", {busy2, lw2}, 32'(3'b111));
        end
        wait_idle();

        // tile_count 0 behaves as 1
        tc = 8'd0; start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            start = 1'b0;
            chk("tc0_done", dn2, 32'(c == 15));
        end
        wait_idle();

        // Five stalled cycles where MULT index 3 would have been presented
        tc = 8'd1; start = 1'b1;
        for (int c = 1; c <= 22; c++) begin
            ge = !(c >= 6 && c <= 10);
            tick();
            start = 1'b0;
            if (c >= 6 && c <= 10) chk("stall_out", {busy2, lw2, em2, td2, dn2}, 32'(7'b1000000));
            if (c == 11) chk("stall_resume", em2, 32'(2'b01));
            chk("stall_done", dn2, 32'(c == 20));
        end
        ge = 1'b1;
        wait_idle();

        // Stall exactly on the done cycle: done once, one cycle late
        start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            ge = (c != 15);
            tick();
            start = 1'b0;
            chk("stall_on_done", dn2, 32'(c == 16));
        end
        ge = 1'b1;
        wait_idle();

        // Reset at MULT index 6 aborts the job silently
        start = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            start = 1'b0;
        end
        rst = 1'b1;
        tick();
        chk("abort_n2", {busy2, lw2, em2, td2, dn2}, 32'(0));
        chk("abort_n4", {busy4, lw4, em4, td4, dn4}, 32'(0));
        rst = 1'b0;
        for (int c = 0; c < 25; c++) begin
            tick();
            chk("abort_no_done", {td2, dn2, td4, dn4}, 32'(0));
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();

        // start held high: back-to-back jobs, one done per job
        n_dn2 = 0; n_dn4 = 0;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (dn2) n_dn2++;
            if (dn4) n_dn4++;
        end
        start = 1'b0;
        chk("held_start_n2", 32'(n_dn2), 32'(4));
        chk("held_start_n4", 32'(n_dn4), 32'(3));
        wait_idle();

        // Randomized traffic against the frame model
        for (int i = 0; i < 500; i++) begin
            rst   = ($urandom_range(0, 149) == 0);
            ge    = ($urandom_range(0, 9) != 0);
            start = ($urandom_range(0, 3) == 0);
            mode  = 1'($urandom_range(0, 1));
            tc    = 8'($urandom_range(0, 3));
            tick();
        end
        rst = 1'b0; ge = 1'b1; start = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
